// File: rtl/eth_fifo_pkg.sv
// ---------------------------------------------------------------------------
// eth_fifo_pkg
// Shared definitions for the Rx async FIFO write side.
//   tag_t       : 2-bit word tag placed above the data byte in each FIFO word
//   EOF_CODE_*  : data byte carried by an EOF_BAD marker word
//   FIFO_WIDTH  : width of a FIFO word, {tag[1:0], data[7:0]}
//   wr_state_t  : write-side frame state
// ---------------------------------------------------------------------------
package eth_fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 10;

    typedef enum logic [1:0] {
        DATA    = 2'b00,
        EOF_OK  = 2'b01,
        EOF_BAD = 2'b10
    } tag_t;

    localparam logic [7:0] EOF_CODE_OVF   = 8'h01;
    localparam logic [7:0] EOF_CODE_RXERR = 8'h02;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DROP,
        ABORT
    } wr_state_t;

    function automatic logic [FIFO_WIDTH-1:0] pack_word(input tag_t tag, input logic [7:0] data);
        return {tag, data};
    endfunction

endpackage

// File: rtl/rx_fifo_writer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : synchronous, active-high reset
//   inc   : add one (ignored once the count is all-ones)
//   clr   : synchronous clear; wins over a same-cycle inc
//   count : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rx_fifo_writer.sv
// ---------------------------------------------------------------------------
// rx_fifo_writer
// Write-side producer for the Rx async FIFO (wclk domain). Registers the
// non-stallable MAC Rx byte stream once and writes tagged words
// {tag[1:0], data[7:0]}. Overflow and Rx errors are folded into EOF_BAD
// markers so every frame seen by the reader ends in EOF_OK or EOF_BAD.
//   wclk, wrst          : clock, synchronous active-high reset
//   in_valid/data/last  : Rx byte stream (no backpressure)
//   in_err              : frame error, sampled with in_valid & in_last
//   fifo_we/fifo_wdata  : FIFO write port (combinational from input register)
//   fifo_wfull          : FIFO full flag, same clock
//   stat_clr            : synchronous clear of all statistics
//   stat_frames_ok/bad/dropped : saturating frame counters
//   stat_overflow       : sticky, a byte was lost to fifo_wfull
// ---------------------------------------------------------------------------
module rx_fifo_writer
    import eth_fifo_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    input  logic                  in_err,
    output logic                  fifo_we,
    output logic [FIFO_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_wfull,
    input  logic                  stat_clr,
    output logic [CNT_WIDTH-1:0]  stat_frames_ok,
    output logic [CNT_WIDTH-1:0]  stat_frames_bad,
    output logic [CNT_WIDTH-1:0]  stat_frames_dropped,
    output logic                  stat_overflow
);

    // Input register stage
    logic       r_valid_q, r_valid_d;
    logic [7:0] r_data_q,  r_data_d;
    logic       r_last_q,  r_last_d;
    logic       r_err_q,   r_err_d;

    // Frame state
    wr_state_t  state_q, state_d;
    logic       need_mark_q, need_mark_d;   // frame in DROP already has words in the FIFO
    logic       skip_q, skip_d;             // a frame opened while the ABORT marker was pending
    logic       overflow_q, overflow_d;

    logic       inc_ok, inc_bad, inc_drop, ovf_set;

    always_comb begin
        r_valid_d = in_valid;
        r_data_d  = in_data;
        r_last_d  = in_valid & in_last;
        r_err_d   = in_valid & in_last & in_err;
    end

    always_comb begin
        state_d     = state_q;
        need_mark_d = need_mark_q;
        skip_d      = skip_q;
        fifo_we     = 1'b0;
        fifo_wdata  = '0;
        inc_ok      = 1'b0;
        inc_bad     = 1'b0;
        inc_drop    = 1'b0;
        ovf_set     = 1'b0;

        case (state_q)
            IDLE, FRAME: begin
                if (r_valid_q) begin
                    if (!fifo_wfull) begin
                        fifo_we = 1'b1;
                        if (r_last_q) begin
                            state_d = IDLE;
                            if (r_err_q) begin
                                // The errored last byte is replaced by the marker.
                                fifo_wdata = pack_word(EOF_BAD, EOF_CODE_RXERR);
                                inc_bad    = 1'b1;
                            end else begin
                                fifo_wdata = pack_word(EOF_OK, r_data_q);
                                inc_ok     = 1'b1;
                            end
                        end else begin
                            fifo_wdata = pack_word(DATA, r_data_q);
                            state_d    = FRAME;
                        end
                    end else begin
                        ovf_set = 1'b1;
                        skip_d  = 1'b0;
                        if (state_q == FRAME) begin
                            // Words already written: the frame must be closed by a marker.
                            need_mark_d = 1'b1;
                            state_d     = r_last_q ? ABORT : DROP;
                        end else begin
                            need_mark_d = 1'b0;
                            if (r_last_q) begin
                                inc_drop = 1'b1;
                                state_d  = IDLE;
                            end else begin
                                state_d = DROP;
                            end
                        end
                    end
                end
            end

            DROP: begin
                if (r_valid_q && r_last_q) begin
                    if (need_mark_q) begin
                        state_d = ABORT;
                        skip_d  = 1'b0;
                    end else begin
                        inc_drop = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            ABORT: begin
                if (r_valid_q) begin
                    ovf_set  = 1'b1;
                    skip_d   = ~r_last_q;
                    inc_drop = r_last_q;
                end
                if (!fifo_wfull) begin
                    fifo_we     = 1'b1;
                    fifo_wdata  = pack_word(EOF_BAD, EOF_CODE_OVF);
                    inc_bad     = 1'b1;
                    need_mark_d = 1'b0;
                    // skip_d already folds in a same-cycle byte: a last byte here
                    // closes the shadow frame, a non-last byte opens one.
                    state_d     = skip_d ? DROP : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        if (stat_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q | ovf_set;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_last_q    <= 1'b0;
            r_err_q     <= 1'b0;
            state_q     <= IDLE;
            need_mark_q <= 1'b0;
            skip_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            r_last_q    <= r_last_d;
            r_err_q     <= r_err_d;
            state_q     <= state_d;
            need_mark_q <= need_mark_d;
            skip_q      <= skip_d;
            overflow_q  <= overflow_d;
        end
    end

    assign stat_overflow = overflow_q;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_ok (
        .clk   (wclk),
        .rst   (wrst),
        .inc   (inc_ok),
        .clr   (stat_clr),
        .count (stat_frames_ok)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_bad (
        .clk   (wclk),
        .rst   (wrst),
        .inc   (inc_bad),
        .clr   (stat_clr),
        .count (stat_frames_bad)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_drop (
        .clk   (wclk),
        .rst   (wrst),
        .inc   (inc_drop),
        .clr   (stat_clr),
        .count (stat_frames_dropped)
    );

endmodule

// File: tb/tb_rx_fifo_writer.sv
// ---------------------------------------------------------------------------
// tb_rx_fifo_writer
// Directed and randomized bench for rx_fifo_writer. A frame-level reference
// model tracks what the reader must see (written words, markers owed,
// discarded frames) and the expected statistics.
// ---------------------------------------------------------------------------
module tb_rx_fifo_writer;

    localparam int MAXCNT = 65535;

    logic        wclk;
    logic        wrst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_err;
    logic        fifo_we;
    logic [9:0]  fifo_wdata;
    logic        fifo_wfull;
    logic        stat_clr;
    logic [15:0] stat_frames_ok;
    logic [15:0] stat_frames_bad;
    logic [15:0] stat_frames_dropped;
    logic        stat_overflow;

    rx_fifo_writer #(.CNT_WIDTH(16)) dut (
        .wclk                (wclk),
        .wrst                (wrst),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_last             (in_last),
        .in_err              (in_err),
        .fifo_we             (fifo_we),
        .fifo_wdata          (fifo_wdata),
        .fifo_wfull          (fifo_wfull),
        .stat_clr            (stat_clr),
        .stat_frames_ok      (stat_frames_ok),
        .stat_frames_bad     (stat_frames_bad),
        .stat_frames_dropped (stat_frames_dropped),
        .stat_overflow       (stat_overflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte delayed by the input register, plus frame status.
    bit       mb_v, mb_l, mb_e;
    bit [7:0] mb_d;
    bit       m_open;    // current frame has words in the FIFO
    bit       m_disc;    // current frame is being thrown away
    bit       m_mark;    // thrown-away frame still owes an EOF_BAD marker
    bit       m_owe;     // marker owed, waiting for room
    bit       m_shadow;  // a new frame is open while the marker is owed
    int       m_ok, m_bad, m_drop;
    bit       m_ovf;

    logic [9:0] got[$];
    logic [9:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c, input bit inc, input bit clr);
        if (clr) return 0;
        if (inc && c < MAXCNT) return c + 1;
        return c;
    endfunction

    task automatic model_reset();
        mb_v = 0; mb_l = 0; mb_e = 0; mb_d = 0;
        m_open = 0; m_disc = 0; m_mark = 0; m_owe = 0; m_shadow = 0;
        m_ok = 0; m_bad = 0; m_drop = 0; m_ovf = 0;
    endtask

    // One wclk cycle: drive inputs, check the write port, then the stats.
    task automatic cycle(input bit v, input bit [7:0] d, input bit l, input bit e,
                         input bit full, input bit clr);
        bit       exp_we;
        bit [9:0] exp_wd;
        bit       iok, ibad, idrop, oset;
        @(negedge wclk);
        in_valid = v; in_data = d; in_last = l; in_err = e;
        fifo_wfull = full; stat_clr = clr;
        #1;
        exp_we = 0; exp_wd = 0; iok = 0; ibad = 0; idrop = 0; oset = 0;
        if (m_owe) begin
            if (mb_v) begin
                oset = 1;
                if (mb_l) idrop = 1;
                m_shadow = !mb_l;
            end
            if (!full) begin
                exp_we = 1; exp_wd = 10'h201; ibad = 1; m_owe = 0;
                if (m_shadow) begin m_disc = 1; m_mark = 0; end
            end
        end else if (m_disc) begin
            if (mb_v && mb_l) begin
                m_disc = 0;
                if (m_mark) begin m_owe = 1; m_shadow = 0; end
                else idrop = 1;
            end
        end else if (mb_v) begin
            if (!full) begin
                exp_we = 1;
                if (!mb_l) begin exp_wd = {2'b00, mb_d}; m_open = 1; end
                else if (mb_e) begin exp_wd = 10'h202; ibad = 1; m_open = 0; end
                else begin exp_wd = {2'b01, mb_d}; iok = 1; m_open = 0; end
            end else begin
                oset = 1;
                if (m_open) begin
                    m_open = 0;
                    if (mb_l) begin m_owe = 1; m_shadow = 0; end
                    else begin m_disc = 1; m_mark = 1; end
                end else if (mb_l) begin
                    idrop = 1;
                end else begin
                    m_disc = 1; m_mark = 0;
                end
            end
        end
        chk("fifo_we", 32'(fifo_we), 32'(exp_we));
        if (exp_we) chk("fifo_wdata", 32'(fifo_wdata), 32'(exp_wd));
        if (fifo_we === 1'b1) got.push_back(fifo_wdata);
        m_ok   = sat(m_ok, iok, clr);
        m_bad  = sat(m_bad, ibad, clr);
        m_drop = sat(m_drop, idrop, clr);
        m_ovf  = clr ? 1'b0 : (m_ovf | oset);
        mb_v = v; mb_d = d; mb_l = v & l; mb_e = v & l & e;
        @(posedge wclk);
        #1;
        chk("frames_ok", 32'(stat_frames_ok), 32'(m_ok));
        chk("frames_bad", 32'(stat_frames_bad), 32'(m_bad));
        chk("frames_dropped", 32'(stat_frames_dropped), 32'(m_drop));
        chk("overflow", 32'(stat_overflow), 32'(m_ovf));
    endtask

    task automatic idle(input int n, input bit full);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, full, 0);
    endtask

    task automatic clear_stats();
        cycle(0, 8'h00, 0, 0, 0, 1);
        got.delete();
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(tag, 32'(got[i]), 32'(exp_q[i]));
        got.delete();
    endtask

    task automatic check_stats(input string tag, input int ok, input int bad,
                               input int drop, input bit ovf);
        chk({tag, "_ok"}, 32'(stat_frames_ok), 32'(ok));
        chk({tag, "_bad"}, 32'(stat_frames_bad), 32'(bad));
        chk({tag, "_dropped"}, 32'(stat_frames_dropped), 32'(drop));
        chk({tag, "_overflow"}, 32'(stat_overflow), 32'(ovf));
    endtask

    // wrst with a byte on the input, as if mid-frame.
    task automatic do_reset(input bit v);
        @(negedge wclk);
        wrst = 1; in_valid = v; in_data = 8'h5A; in_last = 0; in_err = 0;
        fifo_wfull = 0; stat_clr = 0;
        @(posedge wclk);
        #1;
        chk("rst_we", 32'(fifo_we), 32'd0);
        chk("rst_wdata", 32'(fifo_wdata), 32'd0);
        check_stats("rst", 0, 0, 0, 0);
        @(negedge wclk);
        wrst = 0; in_valid = 0;
        model_reset();
        got.delete();
    endtask

    initial begin
        int       flen;
        int       full_left;
        bit       full, v, l, e, clr;
        bit [7:0] d;

        wrst = 1; in_valid = 0; in_data = 0; in_last = 0; in_err = 0;
        fifo_wfull = 0; stat_clr = 0;
        model_reset();
        do_reset(0);

        // Good 4-byte frame
        cycle(1, 8'hAA, 0, 0, 0, 0);
        cycle(1, 8'hBB, 0, 0, 0, 0);
        cycle(1, 8'hCC, 0, 0, 0, 0);
        cycle(1, 8'hDD, 1, 0, 0, 0);
        idle(2, 0);
        exp_q = '{10'h0AA, 10'h0BB, 10'h0CC, 10'h1DD};
        check_writes("good_frame");
        check_stats("good_frame", 1, 0, 0, 0);

        // Rx error on the last byte
        clear_stats();
        cycle(1, 8'hAA, 0, 0, 0, 0);
        cycle(1, 8'hBB, 0, 0, 0, 0);
        cycle(1, 8'hCC, 0, 0, 0, 0);
        cycle(1, 8'hDD, 1, 1, 0, 0);
        idle(2, 0);
        exp_q = '{10'h0AA, 10'h0BB, 10'h0CC, 10'h202};
        check_writes("rxerr_frame");
        check_stats("rxerr_frame", 0, 1, 0, 0);

        // FIFO full from the 2nd byte until 3 cycles after the last
        clear_stats();
        cycle(1, 8'hAA, 0, 0, 0, 0);
        cycle(1, 8'hBB, 0, 0, 0, 0);
        cycle(1, 8'hCC, 0, 0, 1, 0);
        cycle(1, 8'hDD, 1, 0, 1, 0);
        idle(3, 1);
        idle(2, 0);
        exp_q = '{10'h0AA, 10'h201};
        check_writes("ovf_mid");
        check_stats("ovf_mid", 0, 1, 0, 1);

        // FIFO full for a whole 3-byte frame, then a normal frame
        clear_stats();
        cycle(1, 8'hAA, 0, 0, 1, 0);
        cycle(1, 8'hBB, 0, 0, 1, 0);
        cycle(1, 8'hCC, 1, 0, 1, 0);
        idle(1, 1);
        idle(1, 0);
        exp_q = {};
        check_writes("ovf_whole");
        check_stats("ovf_whole", 0, 0, 1, 1);
        cycle(1, 8'hE1, 0, 0, 0, 0);
        cycle(1, 8'hE2, 1, 0, 0, 0);
        idle(2, 0);
        exp_q = '{10'h0E1, 10'h1E2};
        check_writes("after_drop");

        // New frame arrives while the ABORT marker is pending
        clear_stats();
        cycle(1, 8'h11, 0, 0, 0, 0);
        cycle(1, 8'h22, 1, 0, 0, 0);
        cycle(1, 8'h33, 0, 0, 1, 0);
        cycle(1, 8'h44, 0, 0, 1, 0);
        cycle(1, 8'h55, 1, 0, 0, 0);
        idle(1, 0);
        cycle(1, 8'h66, 0, 0, 0, 0);
        cycle(1, 8'h77, 1, 0, 0, 0);
        idle(2, 0);
        exp_q = '{10'h011, 10'h201, 10'h066, 10'h177};
        check_writes("abort_overlap");
        check_stats("abort_overlap", 1, 1, 1, 1);

        // Saturation of frames_ok, then stat_clr against a same-cycle EOF
        clear_stats();
        for (int i = 0; i < MAXCNT + 1; i++) cycle(1, 8'(i), 1, 0, 0, 0);
        idle(1, 0);
        chk("sat_ok", 32'(stat_frames_ok), 32'hFFFF);
        got.delete();
        cycle(1, 8'h42, 1, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 0, 1);
        check_stats("clr_vs_eof", 0, 0, 0, 0);

        // wrst in the middle of a frame
        cycle(1, 8'h99, 1, 0, 0, 0);
        cycle(1, 8'hA0, 0, 0, 0, 0);
        cycle(1, 8'hA1, 0, 0, 0, 0);
        do_reset(1);
        cycle(1, 8'hB0, 1, 0, 0, 0);
        idle(1, 0);
        exp_q = '{10'h1B0};
        check_writes("after_rst");

        // Randomized traffic with bursts of full and occasional clears
        flen = 0; full_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (full_left > 0) begin
                full = 1; full_left--;
            end else begin
                full = 0;
                if ($urandom_range(0, 5) == 0) full_left = int'($urandom_range(1, 6));
            end
            if (flen == 0 && $urandom_range(0, 2) == 0) flen = int'($urandom_range(1, 6));
            v = (flen > 0) && ($urandom_range(0, 4) != 0);
            l = v && (flen == 1);
            e = l && ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            clr = ($urandom_range(0, 96) == 0);
            if (v) flen--;
            cycle(v, d, l, e, full, clr);
        end
        idle(12, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
